// File: rtl/trigger_coinc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trigger_coinc_pkg
// Brief    : Shared defaults, FSM state type and sample magnitude helper for
//            the 8-channel coincidence trigger.
// Revision : 1.0 - initial release
// ============================================================================
package trigger_coinc_pkg;

   localparam int c_NCHAN       = 8;
   localparam int c_NSAMP       = 8;
   localparam int c_SAMPLE_BITS = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      HOLD = 2'd2
   } trig_state_t;

   // Sign-extend by one bit before negating so the most negative code maps to +16.
   function automatic logic [c_SAMPLE_BITS:0] sample_abs(input logic [c_SAMPLE_BITS-1:0] s);
      logic [c_SAMPLE_BITS:0] w;
      w = {s[c_SAMPLE_BITS-1], s};
      return w[c_SAMPLE_BITS] ? -w : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/chan_hit_stretch.sv
`default_nettype none
// ============================================================================
// Module   : chan_hit_stretch
// Brief    : One channel: threshold compare over all samples, hit register
//            and hit stretcher.
// Revision : 1.0 - initial release
// ============================================================================
module chan_hit_stretch
   import trigger_coinc_pkg::*;
#(
   parameter int NSAMP        = c_NSAMP,
   parameter int SAMPLE_BITS  = c_SAMPLE_BITS,
   parameter int STRETCH_BITS = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NSAMP*SAMPLE_BITS-1:0] i_samples,
   input  logic                         i_mask_bit,
   input  logic [SAMPLE_BITS-1:0]       i_thresh,
   input  logic [STRETCH_BITS-1:0]      i_stretch,
   output logic                         o_str
);

   logic                    w_any;
   logic                    r_hit;
   logic [STRETCH_BITS-1:0] r_cnt;

   always_comb begin
      w_any = 1'b0;
      for (int k = 0; k < NSAMP; k++) begin
         if (sample_abs(i_samples[k*SAMPLE_BITS +: SAMPLE_BITS]) >= {1'b0, i_thresh})
            w_any = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_hit <= i_mask_bit & w_any;
         if (r_hit)
            r_cnt <= i_stretch;
         else if (r_cnt != '0)
            r_cnt <= r_cnt - STRETCH_BITS'(1);
      end
   end

   assign o_str = r_hit | (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/trigger_coincidence_x8.sv
`default_nettype none
// ============================================================================
// Module   : trigger_coincidence_x8
// Brief    : N-of-8 coincidence trigger with handshake output, holdoff and
//            saturating accepted/dropped scalers.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_coincidence_x8
   import trigger_coinc_pkg::*;
#(
   parameter int NCHAN        = c_NCHAN,
   parameter int NSAMP        = c_NSAMP,
   parameter int SAMPLE_BITS  = c_SAMPLE_BITS,
   parameter int STRETCH_BITS = 4,
   parameter int HOLDOFF_BITS = 16
) (
   input  logic                                    aclk,
   input  logic                                    aresetn,
   input  logic [NCHAN-1:0][NSAMP*SAMPLE_BITS-1:0] dat_i,
   input  logic                                    enable_i,
   input  logic [4:0]                              thresh_i,
   input  logic [NCHAN-1:0]                        chan_mask_i,
   input  logic [STRETCH_BITS-1:0]                 stretch_i,
   input  logic [3:0]                              coinc_i,
   input  logic [HOLDOFF_BITS-1:0]                 holdoff_i,
   output logic                                    trig_valid_o,
   input  logic                                    trig_ready_i,
   output logic [NCHAN-1:0]                        trig_chans_o,
   output logic [31:0]                             trig_time_o,
   output logic [31:0]                             trig_count_o,
   output logic [31:0]                             drop_count_o
);

   logic [NCHAN-1:0]        w_str;
   logic [3:0]              w_pop;
   logic                    w_coinc;
   logic                    w_coinc_rise;

   logic [31:0]             r_ts;
   logic [31:0]             r_ts_d1;
   logic [31:0]             r_coinc_time;
   logic [NCHAN-1:0]        r_str;
   logic                    r_coinc;
   logic                    r_coinc_d;

   trig_state_t             r_state;
   logic                    r_valid;
   logic [NCHAN-1:0]        r_chans;
   logic [31:0]             r_time;
   logic [HOLDOFF_BITS-1:0] r_hold_cnt;
   logic [31:0]             r_trig_count;
   logic [31:0]             r_drop_count;

   generate
      for (genvar c = 0; c < NCHAN; c++) begin : g_chan
         chan_hit_stretch #(
            .NSAMP        (NSAMP),
            .SAMPLE_BITS  (SAMPLE_BITS),
            .STRETCH_BITS (STRETCH_BITS)
         ) u_chan (
            .clk        (aclk),
            .rst_n      (aresetn),
            .i_samples  (dat_i[c]),
            .i_mask_bit (chan_mask_i[c]),
            .i_thresh   (thresh_i),
            .i_stretch  (stretch_i),
            .o_str      (w_str[c])
         );
      end
   endgenerate

   always_comb begin
      w_pop = '0;
      for (int c = 0; c < NCHAN; c++)
         w_pop = w_pop + 4'(w_str[c]);
   end

   assign w_coinc      = (coinc_i != '0) && (w_pop >= coinc_i);
   assign w_coinc_rise = r_coinc & ~r_coinc_d;

   // The timestamp is delayed twice so it lines up with the registered coincidence.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_ts         <= '0;
         r_ts_d1      <= '0;
         r_coinc_time <= '0;
         r_str        <= '0;
         r_coinc      <= 1'b0;
         r_coinc_d    <= 1'b0;
      end else begin
         r_ts         <= r_ts + 32'd1;
         r_ts_d1      <= r_ts;
         r_coinc_time <= r_ts_d1;
         r_str        <= w_str;
         r_coinc      <= w_coinc;
         r_coinc_d    <= r_coinc;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= IDLE;
         r_valid      <= 1'b0;
         r_chans      <= '0;
         r_time       <= '0;
         r_hold_cnt   <= '0;
         r_trig_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_coinc && enable_i) begin
                  r_valid <= 1'b1;
                  r_chans <= r_str;
                  r_time  <= r_coinc_time;
                  r_state <= PEND;
               end
            end
            PEND: begin
               if (trig_ready_i) begin
                  r_valid <= 1'b0;
                  if (r_trig_count != '1)
                     r_trig_count <= r_trig_count + 32'd1;
                  if (holdoff_i == '0) begin
                     r_state <= IDLE;
                  end else begin
                     r_hold_cnt <= holdoff_i;
                     r_state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               r_hold_cnt <= r_hold_cnt - HOLDOFF_BITS'(1);
               if (r_hold_cnt <= HOLDOFF_BITS'(1))
                  r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // A coincidence that could not be issued: busy, or idle but disarmed.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_drop_count <= '0;
      end else if (w_coinc_rise && (r_state != IDLE || !enable_i) && r_drop_count != '1) begin
         r_drop_count <= r_drop_count + 32'd1;
      end
   end

   assign trig_valid_o = r_valid;
   assign trig_chans_o = r_chans;
   assign trig_time_o  = r_time;
   assign trig_count_o = r_trig_count;
   assign drop_count_o = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_trigger_coincidence_x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_coincidence_x8
// Brief    : Directed self-checking bench for trigger_coincidence_x8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_coincidence_x8;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic [7:0][39:0] dat_i;
   logic             enable_i;
   logic [4:0]       thresh_i;
   logic [7:0]       chan_mask_i;
   logic [3:0]       stretch_i;
   logic [3:0]       coinc_i;
   logic [15:0]      holdoff_i;
   logic             trig_valid_o;
   logic             trig_ready_i;
   logic [7:0]       trig_chans_o;
   logic [31:0]      trig_time_o;
   logic [31:0]      trig_count_o;
   logic [31:0]      drop_count_o;

   always #5 aclk = ~aclk;

   trigger_coincidence_x8 dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .dat_i        (dat_i),
      .enable_i     (enable_i),
      .thresh_i     (thresh_i),
      .chan_mask_i  (chan_mask_i),
      .stretch_i    (stretch_i),
      .coinc_i      (coinc_i),
      .holdoff_i    (holdoff_i),
      .trig_valid_o (trig_valid_o),
      .trig_ready_i (trig_ready_i),
      .trig_chans_o (trig_chans_o),
      .trig_time_o  (trig_time_o),
      .trig_count_o (trig_count_o),
      .drop_count_o (drop_count_o)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] tb_ts;

   // Reference cycle counter: value during the cycle in which dat_i is sampled.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) tb_ts <= '0;
      else          tb_ts <= tb_ts + 32'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge aclk);
   endtask

   task automatic hit_pulse(input int ch, input logic [4:0] v);
      dat_i        = '0;
      dat_i[ch][9:5] = v;
      @(negedge aclk);
      dat_i        = '0;
   endtask

   // Watch n cycles; report valid-high cycle count and the first trigger seen.
   task automatic watch(input int n, output int pulses, output int first_at,
                        output logic [7:0] chans, output logic [31:0] tm);
      pulses   = 0;
      first_at = -1;
      chans    = '0;
      tm       = '0;
      for (int i = 1; i <= n; i++) begin
         @(negedge aclk);
         if (trig_valid_o) begin
            if (pulses == 0) begin
               first_at = i;
               chans    = trig_chans_o;
               tm       = trig_time_o;
            end
            pulses++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   int          pulses, first_at, exp_trig, exp_drop;
   logic [7:0]  ch_seen;
   logic [31:0] tm_seen, tn;
   logic        stable;
   int          pos[$];

   initial begin
      dat_i        = '0;
      enable_i     = 1'b1;
      thresh_i     = 5'd9;
      chan_mask_i  = 8'hFF;
      stretch_i    = 4'd0;
      coinc_i      = 4'd1;
      holdoff_i    = 16'd0;
      trig_ready_i = 1'b1;
      exp_trig     = 0;
      exp_drop     = 0;
      tick(3);
      aresetn = 1'b1;
      tick(2);
      check("rst_valid", trig_valid_o, 0);
      check("rst_chans", trig_chans_o, 0);
      check("rst_time",  trig_time_o, 0);
      check("rst_tcnt",  trig_count_o, 0);
      check("rst_dcnt",  drop_count_o, 0);

      // Single channel at threshold, then just below it
      tn = tb_ts;
      hit_pulse(3, 5'b10111);
      watch(8, pulses, first_at, ch_seen, tm_seen);
      exp_trig++;
      check("thr_pulses", pulses, 1);
      check("thr_latency", first_at, 2);
      check("thr_chans", ch_seen, 8'h08);
      check("thr_time", tm_seen, tn);
      check("thr_tcnt", trig_count_o, exp_trig);
      hit_pulse(3, 5'b11000);
      watch(8, pulses, first_at, ch_seen, tm_seen);
      check("below_pulses", pulses, 0);

      // Stretch bridging a 3-cycle gap between ch0 and ch5
      stretch_i = 4'd3;
      coinc_i   = 4'd2;
      hit_pulse(0, 5'd9);
      tick(2);
      tn = tb_ts;
      hit_pulse(5, 5'd9);
      watch(10, pulses, first_at, ch_seen, tm_seen);
      exp_trig++;
      check("str3_pulses", pulses, 1);
      check("str3_latency", first_at, 2);
      check("str3_chans", ch_seen, 8'h21);
      check("str3_time", tm_seen, tn);
      stretch_i = 4'd2;
      hit_pulse(0, 5'd9);
      tick(2);
      hit_pulse(5, 5'd9);
      watch(10, pulses, first_at, ch_seen, tm_seen);
      check("str2_pulses", pulses, 0);
      check("str2_dcnt", drop_count_o, exp_drop);
      stretch_i = 4'd0;
      coinc_i   = 4'd1;
      tick(4);

      // Backpressure with two extra coincidences while pending
      trig_ready_i = 1'b0;
      tn = tb_ts;
      hit_pulse(1, 5'd9);
      tick(2);
      check("bp_valid", trig_valid_o, 1);
      check("bp_chans", trig_chans_o, 8'h02);
      check("bp_time", trig_time_o, tn);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         dat_i = '0;
         if (i == 1) dat_i[2][4:0] = 5'd9;
         if (i == 5) dat_i[6][4:0] = 5'd9;
         @(negedge aclk);
         if (trig_valid_o !== 1'b1 || trig_chans_o !== 8'h02 || trig_time_o !== tn)
            stable = 1'b0;
      end
      dat_i = '0;
      exp_drop += 2;
      check("bp_stable", stable, 1);
      check("bp_dcnt", drop_count_o, exp_drop);
      check("bp_tcnt_wait", trig_count_o, exp_trig);
      trig_ready_i = 1'b1;
      tick(1);
      exp_trig++;
      check("bp_valid_drop", trig_valid_o, 0);
      check("bp_tcnt", trig_count_o, exp_trig);
      tick(6);

      // Holdoff with continuous hits
      holdoff_i = 16'd5;
      dat_i = '0;
      dat_i[4][4:0] = 5'd9;
      for (int i = 1; i <= 27; i++) begin
         @(negedge aclk);
         if (trig_valid_o) pos.push_back(i);
      end
      dat_i = '0;
      watch(12, pulses, first_at, ch_seen, tm_seen);
      exp_trig += 4;
      check("ho_count", pos.size(), 4);
      check("ho_first", (pos.size() > 0) ? pos[0] : -1, 3);
      for (int j = 1; j < pos.size(); j++)
         check("ho_spacing", pos[j] - pos[j-1], 7);
      check("ho_tail", pulses, 0);
      check("ho_tcnt", trig_count_o, exp_trig);
      check("ho_dcnt", drop_count_o, exp_drop);
      holdoff_i = 16'd0;

      // Edge cases: coinc 0, empty mask, most negative sample
      coinc_i  = 4'd0;
      thresh_i = 5'd0;
      watch(10, pulses, first_at, ch_seen, tm_seen);
      check("coinc0_pulses", pulses, 0);
      thresh_i = 5'd9;
      tick(4);
      coinc_i     = 4'd1;
      chan_mask_i = 8'h00;
      thresh_i    = 5'd0;
      watch(10, pulses, first_at, ch_seen, tm_seen);
      check("mask0_pulses", pulses, 0);
      check("edge_dcnt", drop_count_o, exp_drop);
      thresh_i = 5'd16;
      tick(4);
      chan_mask_i = 8'hFF;
      hit_pulse(7, 5'b10000);
      watch(8, pulses, first_at, ch_seen, tm_seen);
      exp_trig++;
      check("neg16_pulses", pulses, 1);
      check("neg16_chans", ch_seen, 8'h80);
      hit_pulse(7, 5'b01111);
      watch(8, pulses, first_at, ch_seen, tm_seen);
      check("pos15_pulses", pulses, 0);
      thresh_i = 5'd9;

      // Disarmed coincidence counts as a drop
      enable_i = 1'b0;
      hit_pulse(0, 5'd9);
      watch(8, pulses, first_at, ch_seen, tm_seen);
      exp_drop++;
      check("dis_pulses", pulses, 0);
      check("dis_dcnt", drop_count_o, exp_drop);
      enable_i = 1'b1;

      // Disarming while pending does not withdraw the trigger
      trig_ready_i = 1'b0;
      hit_pulse(2, 5'd9);
      tick(2);
      enable_i = 1'b0;
      tick(3);
      check("penden_valid", trig_valid_o, 1);
      trig_ready_i = 1'b1;
      tick(1);
      exp_trig++;
      check("penden_drop", trig_valid_o, 0);
      check("penden_tcnt", trig_count_o, exp_trig);
      enable_i = 1'b1;
      tick(4);

      // Asynchronous reset while pending
      trig_ready_i = 1'b0;
      hit_pulse(1, 5'd9);
      tick(2);
      check("rstp_pre", trig_valid_o, 1);
      #2 aresetn = 1'b0;
      #1;
      check("rstp_valid", trig_valid_o, 0);
      check("rstp_tcnt", trig_count_o, 0);
      check("rstp_dcnt", drop_count_o, 0);
      check("rstp_time", trig_time_o, 0);
      @(negedge aclk);
      aresetn      = 1'b1;
      trig_ready_i = 1'b1;
      hit_pulse(1, 5'd9);
      watch(8, pulses, first_at, ch_seen, tm_seen);
      check("rstp_ts0", tm_seen, 32'd0);
      check("rstp_tcnt1", trig_count_o, 1);

      // Drop scaler saturation
      force dut.r_drop_count = 32'hFFFF_FFFE;
      #1 release dut.r_drop_count;
      enable_i = 1'b0;
      hit_pulse(3, 5'd9);
      tick(5);
      check("sat_first", drop_count_o, 32'hFFFF_FFFF);
      hit_pulse(3, 5'd9);
      tick(5);
      hit_pulse(3, 5'd9);
      tick(5);
      check("sat_hold", drop_count_o, 32'hFFFF_FFFF);
      enable_i = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
